m6502_bus_responder: RTL and testbench



---
 rtl/m6502_bus_responder_pkg.sv | 22 ++
 rtl/m6502_page_ram.sv | 30 +++
 rtl/m6502_bus_responder.sv | 144 ++++++++++++++
 tb/tb_m6502_bus_responder.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/m6502_bus_responder_pkg.sv
// Shared definitions for the m6502 bus responder.
//   - Page numbers that are served from internal RAM.
//   - FSM state encoding used by the responder top.
//   - Default read data returned when an external access times out.
package m6502_bus_responder_pkg;

  localparam logic [7:0] ZERO_PAGE  = 8'h00;
  localparam logic [7:0] STACK_PAGE = 8'h01;

  localparam logic [7:0] ERR_DATA_DEFAULT = 8'hFF;

  typedef enum logic {
    IDLE = 1'b0,
    EXT  = 1'b1
  } state_e;

  // True when the address falls in the zero page or the stack page.
  function automatic logic is_internal(input logic [15:0] a);
    return (a[15:8] == ZERO_PAGE) || (a[15:8] == STACK_PAGE);
  endfunction

endpackage

// File: rtl/m6502_page_ram.sv
// 512x8 RAM backing the zero page and the stack page.
// Ports:
//   clk   - rising-edge clock
//   addr  - shared read/write index (page bit + byte offset)
//   we    - write enable, wdata lands at addr on the rising edge
//   re    - read enable, rdata loads mem[addr] on the rising edge
//   wdata - write data
//   rdata - registered read data, holds between reads
// Contents are not reset.
module m6502_page_ram (
  input  logic       clk,
  input  logic [8:0] addr,
  input  logic       we,
  input  logic       re,
  input  logic [7:0] wdata,
  output logic [7:0] rdata
);

  logic [7:0] mem [512];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/m6502_bus_responder.sv
// Memory-side responder for the m6502 external bus.
// Pages 0x00/0x01 are answered from internal RAM with zero wait states;
// every other page is forwarded to backing memory over a req/ack
// handshake while rdy is held low, with a timeout that aborts the access.
//
// Handshake: an access is accepted on a rising edge where vma=1 and rdy=1.
// While rdy=0 the core holds addr/rw/cpu_dout and vma is ignored.
// ext_req is a level held from acceptance until the edge where ext_ack=1
// is sampled (or the timeout fires); ext_ack is a one-cycle pulse and is
// ignored whenever ext_req is low.
//
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   addr, rw, vma        - core address, 1=read, access qualifier
//   cpu_dout / cpu_din   - write data from core / registered read data
//   rdy                  - 1 = responder ready
//   ext_req, ext_we      - external request level, 1 = external write
//   ext_addr, ext_wdata  - registered external address and write data
//   ext_ack, ext_rdata   - completion pulse and read data from memory
//   bus_err              - one-cycle pulse when an external access times out
module m6502_bus_responder
  import m6502_bus_responder_pkg::*;
#(
  parameter int unsigned TIMEOUT  = 16,
  parameter logic [7:0]  ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] addr,
  input  logic        rw,
  input  logic        vma,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_din,
  output logic        rdy,
  output logic        ext_req,
  output logic        ext_we,
  output logic [15:0] ext_addr,
  output logic [7:0]  ext_wdata,
  input  logic        ext_ack,
  input  logic [7:0]  ext_rdata,
  output logic        bus_err
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_e     state, state_nxt;
  logic [7:0] cnt;
  logic [7:0] ext_din;     // last external read result (or ERR_DATA)
  logic       din_is_ram;  // cpu_din currently sourced from the RAM read register
  logic [7:0] ram_rdata;

  logic accept, internal, ram_we, ram_re, timeout_hit;

  assign accept      = vma && (state == IDLE);
  assign internal    = is_internal(addr);
  assign ram_we      = accept && internal && !rw;
  assign ram_re      = accept && internal && rw;
  // Ack takes priority over the timeout when both land on the same cycle.
  assign timeout_hit = (state == EXT) && !ext_ack && (cnt == TO_LAST);

  m6502_page_ram u_ram (
    .clk   (clk),
    .addr  (addr[8:0]),
    .we    (ram_we),
    .re    (ram_re),
    .wdata (cpu_dout),
    .rdata (ram_rdata)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept && !internal)         state_nxt = EXT;
      EXT:  if (ext_ack || timeout_hit)      state_nxt = IDLE;
      default:                               state_nxt = IDLE;
    endcase
  end

  // Outputs: rdy/ext_req follow the state register directly, so an
  // asynchronous reset releases the core and drops the request at once.
  // The RAM read register and ext_din both hold between loads, so the
  // muxed cpu_din holds too.
  always_comb begin
    rdy     = (state == IDLE);
    ext_req = (state == EXT);
    cpu_din = din_is_ram ? ram_rdata : ext_din;
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_addr   <= 16'h0000;
      ext_we     <= 1'b0;
      ext_wdata  <= 8'h00;
      ext_din    <= 8'h00;
      din_is_ram <= 1'b0;
      cnt        <= 8'h00;
      bus_err    <= 1'b0;
    end else begin
      bus_err <= 1'b0;
      case (state)
        IDLE: begin
          if (ram_re) begin
            din_is_ram <= 1'b1;
          end
          if (accept && !internal) begin
            ext_addr  <= addr;
            ext_we    <= ~rw;
            ext_wdata <= cpu_dout;
            cnt       <= 8'h00;
          end
        end
        EXT: begin
          if (ext_ack) begin
            if (!ext_we) begin
              ext_din    <= ext_rdata;
              din_is_ram <= 1'b0;
            end
          end else if (timeout_hit) begin
            bus_err <= 1'b1;
            if (!ext_we) begin
              ext_din    <= ERR_DATA;
              din_is_ram <= 1'b0;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_m6502_bus_responder.sv
module tb_m6502_bus_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic        rw = 1'b1;
  logic        vma = 1'b0;
  logic [7:0]  cpu_dout = 8'h00;
  logic [7:0]  cpu_din;
  logic        rdy;
  logic        ext_req;
  logic        ext_we;
  logic [15:0] ext_addr;
  logic [7:0]  ext_wdata;
  logic        ext_ack = 1'b0;
  logic [7:0]  ext_rdata = 8'h00;
  logic        bus_err;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_v;

  m6502_bus_responder #(.TIMEOUT(16), .ERR_DATA(8'hFF)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .addr      (addr),
    .rw        (rw),
    .vma       (vma),
    .cpu_dout  (cpu_dout),
    .cpu_din   (cpu_din),
    .rdy       (rdy),
    .ext_req   (ext_req),
    .ext_we    (ext_we),
    .ext_addr  (ext_addr),
    .ext_wdata (ext_wdata),
    .ext_ack   (ext_ack),
    .ext_rdata (ext_rdata),
    .bus_err   (bus_err)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks: inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [15:0] a, input logic r, input logic [7:0] d);
    addr = a; rw = r; cpu_dout = d; vma = 1'b1;
    tick();
    vma = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_cmp++; if (rdy !== 1'b1)          begin n_fail++; $display("FAIL reset_rdy: got %b want 1", rdy); end
    n_cmp++; if (cpu_din !== 8'h00)     begin n_fail++; $display("FAIL reset_cpu_din: got %h want 00", cpu_din); end
    n_cmp++; if (ext_req !== 1'b0)      begin n_fail++; $display("FAIL reset_ext_req: got %b want 0", ext_req); end
    n_cmp++; if (ext_we !== 1'b0)       begin n_fail++; $display("FAIL reset_ext_we: got %b want 0", ext_we); end
    n_cmp++; if (ext_addr !== 16'h0000) begin n_fail++; $display("FAIL reset_ext_addr: got %h want 0000", ext_addr); end
    n_cmp++; if (ext_wdata !== 8'h00)   begin n_fail++; $display("FAIL reset_ext_wdata: got %h want 00", ext_wdata); end
    n_cmp++; if (bus_err !== 1'b0)      begin n_fail++; $display("FAIL reset_bus_err: got %b want 0", bus_err); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_internal_rw();
    issue(16'h0010, 1'b0, 8'h5A);
    n_cmp++; if (rdy !== 1'b1 || ext_req !== 1'b0) begin n_fail++; $display("FAIL int_wr_bus: rdy=%b ext_req=%b want 1/0", rdy, ext_req); end
    exp_q.push_back(8'h5A);
    issue(16'h0010, 1'b1, 8'h00);
    exp_v = exp_q.pop_front();
    n_cmp++; if (cpu_din !== exp_v) begin n_fail++; $display("FAIL int_rd_0010: got %h want %h", cpu_din, exp_v); end
    n_cmp++; if (rdy !== 1'b1 || ext_req !== 1'b0) begin n_fail++; $display("FAIL int_rd_bus: rdy=%b ext_req=%b want 1/0", rdy, ext_req); end
  endtask

  task automatic test_back_to_back();
    issue(16'h01FF, 1'b0, 8'hC3);
    exp_q.push_back(8'hC3);
    exp_q.push_back(8'h5A);
    addr = 16'h01FF; rw = 1'b1; vma = 1'b1;
    tick();
    exp_v = exp_q.pop_front();
    n_cmp++; if (cpu_din !== exp_v) begin n_fail++; $display("FAIL b2b_rd_01ff: got %h want %h", cpu_din, exp_v); end
    addr = 16'h0010;
    tick();
    vma = 1'b0;
    exp_v = exp_q.pop_front();
    n_cmp++; if (cpu_din !== exp_v) begin n_fail++; $display("FAIL b2b_rd_0010: got %h want %h", cpu_din, exp_v); end
    n_cmp++; if (ext_req !== 1'b0) begin n_fail++; $display("FAIL b2b_ext_req: got %b want 0", ext_req); end
  endtask

  task automatic test_ext_read();
    issue(16'h1234, 1'b1, 8'h00);  // accepted at T0
    for (int t = 1; t <= 3; t++) begin
      n_cmp++; if (ext_req !== 1'b1 || rdy !== 1'b0) begin n_fail++; $display("FAIL ext_rd_wait_T%0d: ext_req=%b rdy=%b want 1/0", t, ext_req, rdy); end
      if (t == 3) begin ext_ack = 1'b1; ext_rdata = 8'hA7; end
      else tick();
    end
    n_cmp++; if (ext_addr !== 16'h1234 || ext_we !== 1'b0) begin n_fail++; $display("FAIL ext_rd_addr: addr=%h we=%b want 1234/0", ext_addr, ext_we); end
    tick();
    ext_ack = 1'b0; ext_rdata = 8'h00;
    n_cmp++; if (rdy !== 1'b1 || ext_req !== 1'b0) begin n_fail++; $display("FAIL ext_rd_done: rdy=%b ext_req=%b want 1/0", rdy, ext_req); end
    n_cmp++; if (cpu_din !== 8'hA7) begin n_fail++; $display("FAIL ext_rd_data: got %h want a7", cpu_din); end
    n_cmp++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL ext_rd_err: got %b want 0", bus_err); end
  endtask

  task automatic test_ext_write();
    issue(16'h8000, 1'b0, 8'h3C);
    n_cmp++; if (ext_req !== 1'b1 || ext_we !== 1'b1 || ext_wdata !== 8'h3C || ext_addr !== 16'h8000) begin
      n_fail++; $display("FAIL ext_wr_bus: req=%b we=%b wdata=%h addr=%h want 1/1/3c/8000", ext_req, ext_we, ext_wdata, ext_addr);
    end
    ext_ack = 1'b1;
    tick();
    ext_ack = 1'b0;
    n_cmp++; if (rdy !== 1'b1 || ext_req !== 1'b0) begin n_fail++; $display("FAIL ext_wr_done: rdy=%b ext_req=%b want 1/0", rdy, ext_req); end
    n_cmp++; if (cpu_din !== 8'hA7) begin n_fail++; $display("FAIL ext_wr_din: got %h want a7", cpu_din); end
    n_cmp++; if (ext_addr !== 16'h8000 || ext_wdata !== 8'h3C) begin n_fail++; $display("FAIL ext_wr_hold: addr=%h wdata=%h want 8000/3c", ext_addr, ext_wdata); end
  endtask

  task automatic test_stray_ack();
    ext_ack = 1'b1; ext_rdata = 8'hEE;
    tick();
    ext_ack = 1'b0;
    tick();
    n_cmp++; if (cpu_din !== 8'hA7 || ext_req !== 1'b0 || bus_err !== 1'b0) begin
      n_fail++; $display("FAIL stray_ack: din=%h req=%b err=%b want a7/0/0", cpu_din, ext_req, bus_err);
    end
  endtask

  task automatic test_timeout();
    int hi;
    hi = 0;
    issue(16'h4000, 1'b1, 8'h00);
    while (ext_req === 1'b1 && hi < 40) begin
      hi++;
      tick();
    end
    n_cmp++; if (hi != 16) begin n_fail++; $display("FAIL to_req_cycles: got %0d want 16", hi); end
    n_cmp++; if (bus_err !== 1'b1) begin n_fail++; $display("FAIL to_bus_err: got %b want 1", bus_err); end
    n_cmp++; if (cpu_din !== 8'hFF || rdy !== 1'b1) begin n_fail++; $display("FAIL to_data: din=%h rdy=%b want ff/1", cpu_din, rdy); end
    tick();
    n_cmp++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL to_err_pulse: got %b want 0", bus_err); end
  endtask

  task automatic test_ack_at_timeout();
    issue(16'h4000, 1'b1, 8'h00);
    repeat (15) tick();
    n_cmp++; if (ext_req !== 1'b1) begin n_fail++; $display("FAIL late_ack_req16: got %b want 1", ext_req); end
    ext_ack = 1'b1; ext_rdata = 8'h66;
    tick();
    ext_ack = 1'b0;
    n_cmp++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL late_ack_err: got %b want 0", bus_err); end
    n_cmp++; if (cpu_din !== 8'h66 || rdy !== 1'b1 || ext_req !== 1'b0) begin
      n_fail++; $display("FAIL late_ack_data: din=%h rdy=%b req=%b want 66/1/0", cpu_din, rdy, ext_req);
    end
    tick();
    n_cmp++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL late_ack_err2: got %b want 0", bus_err); end
  endtask

  task automatic test_reset_mid_ext();
    issue(16'h2000, 1'b1, 8'h00);
    repeat (4) tick();  // now in cycle 5 of ext_req
    n_cmp++; if (ext_req !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre: ext_req=%b want 1", ext_req); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (ext_req !== 1'b0 || rdy !== 1'b1) begin n_fail++; $display("FAIL rst_mid_async: ext_req=%b rdy=%b want 0/1", ext_req, rdy); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    issue(16'h0010, 1'b1, 8'h00);
    n_cmp++; if (cpu_din !== 8'h5A || rdy !== 1'b1) begin n_fail++; $display("FAIL rst_mid_after: din=%h rdy=%b want 5a/1", cpu_din, rdy); end
  endtask

  initial begin
    test_reset();
    test_internal_rw();
    test_back_to_back();
    test_ext_read();
    test_ext_write();
    test_stray_ack();
    test_timeout();
    test_ack_at_timeout();
    test_reset_mid_ext();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
